vram_writer: RTL and testbench
==============================

VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 SHALL have parameter PIX_W, default 24, width of the per-frame pixel count (matches the vram pixel counter).
REQ-002 SHALL have ports: clk_sys in 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n in 1: reset is asynchronous and active-low.
REQ-004 SHALL have port frame_start in 1: one-cycle pulse that arms a new frame.
REQ-005 SHALL have port frame_pixels in PIX_W: pixels expected in the frame (H*V), sampled on frame_start.
REQ-006 SHALL have port rgb565 in 1: pixel format, sampled on frame_start (0 = RGB888, 3 bytes/pixel; 1 = RGB565, 2 bytes/pixel, low byte first).
REQ-007 SHALL have ports s_data in 8, s_valid in 1, s_ready out 1: inbound byte stream; a byte transfers when s_valid && s_ready at the clock edge.
REQ-008 SHALL have port vram_ready in 1: the vram sink can accept a pixel.
REQ-009 SHALL have port vram_req out 1: the pixel on r/g/b_vram_out is offered.
REQ-010 SHALL have ports r_vram_out, g_vram_out, b_vram_out, out 8 each: pixel data.
REQ-011 SHALL have ports pixels_written out PIX_W, frame_done out 1 (one-cycle pulse), busy out 1.

Function
REQ-012 SHALL implement FSM states IDLE, COLLECT, PUSH, DONE; busy = (state is COLLECT or PUSH).
REQ-013 SHALL leave IDLE or DONE for COLLECT on frame_start when frame_pixels != 0, and clear the byte index and pixels_written.
REQ-014 SHALL ignore frame_start when frame_pixels == 0; the state is unchanged.
REQ-015 SHALL drive s_ready high only in COLLECT, combinationally from the state register.
REQ-016 RGB888 byte order SHALL be R, G, B; the third accepted byte moves the FSM to PUSH on the next cycle with the pixel latched.
REQ-017 RGB565: byte0 = d[7:0], byte1 = d[15:8]; expansion SHALL be r={d[15:11],d[15:13]}, g={d[10:5],d[10:9]}, b={d[4:0],d[4:2]}; the second byte moves the FSM to PUSH.
REQ-018 SHALL hold vram_req high (registered) for the whole of PUSH, and hold pixel outputs stable from PUSH entry until the next push completes (at least 1 cycle after the accepting edge).
REQ-019 A push SHALL complete on the edge where vram_req && vram_ready: pixels_written increments by 1; the next state is DONE if the new count == frame_pixels_latched, else COLLECT.
REQ-020 If vram_ready stays low, SHALL remain in PUSH indefinitely with s_ready low (backpressure); no byte is lost or accepted.
REQ-021 SHALL pulse frame_done for exactly the cycle after the completing push of the final pixel.
REQ-022 In DONE, s_ready and vram_req SHALL be 0; pixels_written holds the final count until the next frame_start.
REQ-023 frame_start during COLLECT SHALL discard the partial pixel and restart (count 0, byte index 0).
REQ-024 frame_start during PUSH: if the push completes on the same edge it counts toward the old frame, then the restart applies; otherwise the pending pixel is dropped. In both cases the result is COLLECT with count 0 and no frame_done.
REQ-025 Arithmetic SHALL be unsigned PIX_W-bit; the count never exceeds frame_pixels_latched.

Reset
REQ-026 On reset_n low, immediately and asynchronously: state IDLE, s_ready 0, vram_req 0, r/g/b_vram_out 0, pixels_written 0, frame_done 0, busy 0, byte index 0, latched format RGB888, latched frame_pixels 0.
REQ-027 After reset_n deasserts, SHALL stay in IDLE until a valid frame_start.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, PIX_W default, and format encodings (FMT_RGB888=0, FMT_RGB565=1).
REQ-029 One sub-module, vram_px_unpack, SHALL perform byte assembly and RGB565 expansion; the FSM and counters stay in vram_writer.

Verification
REQ-030 RGB888: frame_pixels=2, bytes 11 22 33 44 55 66, vram_ready=1 -> two pushes (11,22,33) then (44,55,66); frame_done one cycle after the 2nd accept; pixels_written=2.
REQ-031 RGB565: frame_pixels=1, bytes 00 F8 -> pixel (FF,00,00); bytes E0 07 on a new frame -> (00,FF,00).
REQ-032 Backpressure: vram_ready=0 for 10 cycles during PUSH -> vram_req held, outputs stable, s_ready 0, no byte consumed; completes 1 cycle after vram_ready=1.
REQ-033 Restart: frame_start after 1 of 3 RGB888 bytes -> partial byte discarded; next bytes AA BB CC give pixel (AA,BB,CC); count 1.
REQ-034 Async reset mid-PUSH (reset_n low between edges) -> vram_req and all outputs 0 immediately; state IDLE; frame_start with frame_pixels=0 afterwards -> stays IDLE.

Source files
------------

// File: rtl/vram_writer_pkg.sv
// -----------------------------------------------------------------------------
// vram_writer_pkg
// Shared definitions for the VRAM writer: FSM state encoding, the default
// pixel-counter width and the pixel format encodings used on rgb565.
// -----------------------------------------------------------------------------
package vram_writer_pkg;

   // Default width of the per-frame pixel counter (matches the vram counter).
   localparam int PIX_W_DEF = 24;

   // Pixel format encodings as seen on the rgb565 input.
   localparam logic FMT_RGB888 = 1'b0;   // 3 bytes per pixel: R, G, B
   localparam logic FMT_RGB565 = 1'b1;   // 2 bytes per pixel, low byte first

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PUSH    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

endpackage : vram_writer_pkg

// File: rtl/vram_px_unpack.sv
// -----------------------------------------------------------------------------
// vram_px_unpack
// Assembles inbound bytes into one pixel and expands RGB565 to 8-bit channels.
//
// Ports
//   clk_sys      in  system clock, rising edge
//   reset_n      in  asynchronous active-low reset
//   clear        in  drop any partial pixel and return to byte 0
//   byte_valid   in  a byte transfers on this edge
//   byte_data    in  the transferring byte
//   fmt          in  latched pixel format (FMT_RGB888 / FMT_RGB565)
//   pix_complete out this byte completes a pixel (combinational)
//   pix_r/g/b    out assembled pixel, valid while pix_complete is high
// -----------------------------------------------------------------------------
module vram_px_unpack
   import vram_writer_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic       fmt,
   output logic       pix_complete,
   output logic [7:0] pix_r,
   output logic [7:0] pix_g,
   output logic [7:0] pix_b
);

   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [7:0]  byte0_q, byte0_d;
   logic [7:0]  byte1_q, byte1_d;
   logic [1:0]  last_idx;
   logic [15:0] word565;

   // Index of the byte that finishes a pixel for the current format.
   assign last_idx     = (fmt == FMT_RGB565) ? 2'd1 : 2'd2;
   assign pix_complete = byte_valid && (byte_idx_q == last_idx);

   // The final byte is used straight from the bus so the pixel is available
   // on the same edge that accepts it.
   assign word565 = {byte_data, byte0_q};

   always_comb begin
      pix_r = byte0_q;
      pix_g = byte1_q;
      pix_b = byte_data;
      if (fmt == FMT_RGB565) begin
         // Replicate the MSBs into the LSBs so full-scale maps to 8'hFF.
         pix_r = {word565[15:11], word565[15:13]};
         pix_g = {word565[10:5],  word565[10:9]};
         pix_b = {word565[4:0],   word565[4:2]};
      end
   end

   always_comb begin
      byte_idx_d = byte_idx_q;
      byte0_d    = byte0_q;
      byte1_d    = byte1_q;
      if (clear) begin
         byte_idx_d = 2'd0;
      end else if (byte_valid) begin
         if (pix_complete) begin
            byte_idx_d = 2'd0;
         end else begin
            byte_idx_d = byte_idx_q + 2'd1;
         end
         if (byte_idx_q == 2'd0) begin
            byte0_d = byte_data;
         end
         if (byte_idx_q == 2'd1) begin
            byte1_d = byte_data;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         byte_idx_q <= 2'd0;
         byte0_q    <= 8'd0;
         byte1_q    <= 8'd0;
      end else begin
         byte_idx_q <= byte_idx_d;
         byte0_q    <= byte0_d;
         byte1_q    <= byte1_d;
      end
   end

endmodule : vram_px_unpack

// File: rtl/vram_writer.sv
// -----------------------------------------------------------------------------
// vram_writer
// Collects a byte stream into RGB pixels and pushes them one at a time to a
// vram sink, counting pixels until the frame is complete.
//
// Ports
//   clk_sys        in  system clock, rising edge
//   reset_n        in  asynchronous active-low reset
//   frame_start    in  one-cycle pulse arming a new frame
//   frame_pixels   in  pixel count of the frame, sampled on frame_start
//   rgb565         in  pixel format, sampled on frame_start
//   s_data/s_valid in  inbound byte stream
//   s_ready        out byte stream ready (COLLECT only)
//   vram_ready     in  sink accepts a pixel
//   vram_req       out pixel offered to the sink
//   r/g/b_vram_out out pixel data
//   pixels_written out pixels pushed in the current frame
//   frame_done     out pulse the cycle after the final pixel is accepted
//   busy           out collecting or pushing
// -----------------------------------------------------------------------------
module vram_writer
   import vram_writer_pkg::*;
#(
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             frame_start,
   input  logic [PIX_W-1:0] frame_pixels,
   input  logic             rgb565,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             vram_ready,
   output logic             vram_req,
   output logic [7:0]       r_vram_out,
   output logic [7:0]       g_vram_out,
   output logic [7:0]       b_vram_out,
   output logic [PIX_W-1:0] pixels_written,
   output logic             frame_done,
   output logic             busy
);

   localparam logic [PIX_W-1:0] ONE = {{(PIX_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             fmt_q, fmt_d;
   logic [PIX_W-1:0] frame_pixels_q, frame_pixels_d;
   logic [PIX_W-1:0] count_q, count_d;
   logic             frame_done_q, frame_done_d;
   logic             vram_req_q, vram_req_d;
   logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;

   logic             start_ok;
   logic             accept;
   logic             push_ok;
   logic [PIX_W-1:0] count_inc;
   logic             pix_complete;
   logic [7:0]       pix_r, pix_g, pix_b;

   assign s_ready   = (state_q == ST_COLLECT);
   assign accept    = s_valid && s_ready;
   assign push_ok   = vram_req_q && vram_ready;
   assign start_ok  = frame_start && (frame_pixels != '0);
   assign count_inc = count_q + ONE;

   vram_px_unpack u_unpack (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .clear        (start_ok),
      .byte_valid   (accept),
      .byte_data    (s_data),
      .fmt          (fmt_q),
      .pix_complete (pix_complete),
      .pix_r        (pix_r),
      .pix_g        (pix_g),
      .pix_b        (pix_b)
   );

   always_comb begin
      state_d        = state_q;
      fmt_d          = fmt_q;
      frame_pixels_d = frame_pixels_q;
      count_d        = count_q;
      frame_done_d   = 1'b0;
      r_d            = r_q;
      g_d            = g_q;
      b_d            = b_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               state_d = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            // A restart wins over a pixel completing on the same edge.
            if (!start_ok && pix_complete) begin
               state_d = ST_PUSH;
               r_d     = pix_r;
               g_d     = pix_g;
               b_d     = pix_b;
            end
         end
         ST_PUSH: begin
            if (push_ok) begin
               count_d = count_inc;
               if (count_inc == frame_pixels_q) begin
                  state_d      = ST_DONE;
                  frame_done_d = 1'b1;
               end else begin
                  state_d = ST_COLLECT;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Arming a new frame overrides whatever the old frame was doing; a push
      // that completes on this edge has already been counted above and is
      // simply discarded with the old count.
      if (start_ok) begin
         state_d        = ST_COLLECT;
         fmt_d          = rgb565;
         frame_pixels_d = frame_pixels;
         count_d        = '0;
         frame_done_d   = 1'b0;
      end
   end

   assign vram_req_d = (state_d == ST_PUSH);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         fmt_q          <= FMT_RGB888;
         frame_pixels_q <= '0;
         count_q        <= '0;
         frame_done_q   <= 1'b0;
         vram_req_q     <= 1'b0;
         r_q            <= 8'd0;
         g_q            <= 8'd0;
         b_q            <= 8'd0;
      end else begin
         state_q        <= state_d;
         fmt_q          <= fmt_d;
         frame_pixels_q <= frame_pixels_d;
         count_q        <= count_d;
         frame_done_q   <= frame_done_d;
         vram_req_q     <= vram_req_d;
         r_q            <= r_d;
         g_q            <= g_d;
         b_q            <= b_d;
      end
   end

   assign vram_req       = vram_req_q;
   assign r_vram_out     = r_q;
   assign g_vram_out     = g_q;
   assign b_vram_out     = b_q;
   assign pixels_written = count_q;
   assign frame_done     = frame_done_q;
   assign busy           = (state_q == ST_COLLECT) || (state_q == ST_PUSH);

endmodule : vram_writer

// File: tb/tb_vram_writer.sv
// -----------------------------------------------------------------------------
// tb_vram_writer
// Directed and randomized stimulus for vram_writer, checked against a
// behavioural pixel model.
// -----------------------------------------------------------------------------
module tb_vram_writer;

   localparam int PW = 24;

   logic          clk_sys;
   logic          reset_n;
   logic          frame_start;
   logic [PW-1:0] frame_pixels;
   logic          rgb565;
   logic [7:0]    s_data;
   logic          s_valid;
   logic          s_ready;
   logic          vram_ready;
   logic          vram_req;
   logic [7:0]    r_vram_out, g_vram_out, b_vram_out;
   logic [PW-1:0] pixels_written;
   logic          frame_done;
   logic          busy;

   int checks = 0;
   int errors = 0;

   vram_writer #(.PIX_W(PW)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .frame_start    (frame_start),
      .frame_pixels   (frame_pixels),
      .rgb565         (rgb565),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .vram_ready     (vram_ready),
      .vram_req       (vram_req),
      .r_vram_out     (r_vram_out),
      .g_vram_out     (g_vram_out),
      .b_vram_out     (b_vram_out),
      .pixels_written (pixels_written),
      .frame_done     (frame_done),
      .busy           (busy)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference pixel: RGB888 is the bytes in order; RGB565 is a little-endian
   // 16-bit word whose 5/6/5 fields are scaled to 8 bits by MSB replication.
   function automatic logic [23:0] model_pixel(input logic fmt, input logic [7:0] b0,
                                               input logic [7:0] b1, input logic [7:0] b2);
      int d, r5, g6, b5;
      logic [7:0] r, g, b;
      if (fmt) begin
         d  = int'(b1) * 256 + int'(b0);
         r5 = d / 2048;
         g6 = (d / 32) % 64;
         b5 = d % 32;
         r  = 8'(r5 * 8 + r5 / 4);
         g  = 8'(g6 * 4 + g6 / 16);
         b  = 8'(b5 * 8 + b5 / 4);
      end else begin
         r = b0;
         g = b1;
         b = b2;
      end
      return {r, g, b};
   endfunction

   task automatic start_frame(input int fp, input logic fmt);
      @(negedge clk_sys);
      frame_start  = 1'b1;
      frame_pixels = PW'(fp);
      rgb565       = fmt;
      @(negedge clk_sys);
      frame_start  = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      @(negedge clk_sys);
      s_valid = 1'b1;
      s_data  = b;
      n = 0;
      while (!s_ready && n < 50) begin
         @(negedge clk_sys);
         n++;
      end
      check("s_ready_wait", {31'd0, s_ready}, 32'd1);
      @(negedge clk_sys);
      s_valid = 1'b0;
   endtask

   task automatic send_pixel(input logic fmt, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0);
      send_byte(b1);
      if (!fmt) send_byte(b2);
   endtask

   task automatic push_pixel(input logic [23:0] exp_px, input int stall,
                             input int exp_count, input bit exp_done);
      int n;
      n = 0;
      while (!vram_req && n < 50) begin
         @(negedge clk_sys);
         n++;
      end
      check("vram_req", {31'd0, vram_req}, 32'd1);
      check("s_ready_in_push", {31'd0, s_ready}, 32'd0);
      check("pixel", {8'd0, r_vram_out, g_vram_out, b_vram_out}, {8'd0, exp_px});
      for (int i = 0; i < stall; i++) begin
         @(negedge clk_sys);
         check("stall_req", {31'd0, vram_req}, 32'd1);
         check("stall_pixel", {8'd0, r_vram_out, g_vram_out, b_vram_out}, {8'd0, exp_px});
      end
      vram_ready = 1'b1;
      @(negedge clk_sys);
      vram_ready = 1'b0;
      check("pixels_written", 32'(pixels_written), 32'(exp_count));
      check("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
      check("busy_after_push", {31'd0, busy}, {31'd0, !exp_done});
      check("pixel_hold", {8'd0, r_vram_out, g_vram_out, b_vram_out}, {8'd0, exp_px});
      if (exp_done) begin
         @(negedge clk_sys);
         check("frame_done_pulse", {31'd0, frame_done}, 32'd0);
         check("done_count_hold", 32'(pixels_written), 32'(exp_count));
         check("done_req", {31'd0, vram_req}, 32'd0);
      end
   endtask

   initial begin
      logic [7:0]  b0, b1, b2;
      logic        fmt;
      int          fp;
      int          last_fp;

      reset_n      = 1'b0;
      frame_start  = 1'b0;
      frame_pixels = '0;
      rgb565       = 1'b0;
      s_data       = 8'd0;
      s_valid      = 1'b0;
      vram_ready   = 1'b0;
      last_fp      = 0;

      // Reset state
      repeat (2) @(negedge clk_sys);
      check("rst_vram_req", {31'd0, vram_req}, 32'd0);
      check("rst_s_ready", {31'd0, s_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_count", 32'(pixels_written), 32'd0);
      check("rst_pixel", {8'd0, r_vram_out, g_vram_out, b_vram_out}, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("idle_after_reset", {31'd0, busy}, 32'd0);

      // RGB888, two pixels
      start_frame(2, 1'b0);
      check("start_count", 32'(pixels_written), 32'd0);
      check("start_s_ready", {31'd0, s_ready}, 32'd1);
      send_pixel(1'b0, 8'h11, 8'h22, 8'h33);
      push_pixel(model_pixel(1'b0, 8'h11, 8'h22, 8'h33), 0, 1, 1'b0);
      send_pixel(1'b0, 8'h44, 8'h55, 8'h66);
      push_pixel(model_pixel(1'b0, 8'h44, 8'h55, 8'h66), 0, 2, 1'b1);

      // RGB565 red then green
      start_frame(1, 1'b1);
      send_pixel(1'b1, 8'h00, 8'hF8, 8'h00);
      push_pixel(model_pixel(1'b1, 8'h00, 8'hF8, 8'h00), 0, 1, 1'b1);
      start_frame(1, 1'b1);
      send_pixel(1'b1, 8'hE0, 8'h07, 8'h00);
      push_pixel(model_pixel(1'b1, 8'hE0, 8'h07, 8'h00), 0, 1, 1'b1);

      // Backpressure: a byte waits on the bus for 10 stalled cycles
      start_frame(2, 1'b0);
      send_pixel(1'b0, 8'h01, 8'h02, 8'h03);
      s_valid = 1'b1;
      s_data  = 8'h77;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_sys);
         check("bp_req", {31'd0, vram_req}, 32'd1);
         check("bp_s_ready", {31'd0, s_ready}, 32'd0);
         check("bp_pixel", {8'd0, r_vram_out, g_vram_out, b_vram_out}, 32'h010203);
         check("bp_count", 32'(pixels_written), 32'd0);
      end
      vram_ready = 1'b1;
      @(negedge clk_sys);
      vram_ready = 1'b0;
      check("bp_complete_count", 32'(pixels_written), 32'd1);
      check("bp_collect", {31'd0, s_ready}, 32'd1);
      send_byte(8'h88);
      send_byte(8'h99);
      push_pixel(model_pixel(1'b0, 8'h77, 8'h88, 8'h99), 2, 2, 1'b1);

      // Restart mid-pixel
      start_frame(3, 1'b0);
      send_byte(8'h5A);
      start_frame(3, 1'b0);
      check("restart_count", 32'(pixels_written), 32'd0);
      send_pixel(1'b0, 8'hAA, 8'hBB, 8'hCC);
      push_pixel(model_pixel(1'b0, 8'hAA, 8'hBB, 8'hCC), 1, 1, 1'b0);

      // frame_start during PUSH with the push completing on the same edge
      send_pixel(1'b0, 8'h10, 8'h20, 8'h30);
      @(negedge clk_sys);
      frame_start  = 1'b1;
      frame_pixels = PW'(3);
      rgb565       = 1'b0;
      vram_ready   = 1'b1;
      @(negedge clk_sys);
      frame_start  = 1'b0;
      vram_ready   = 1'b0;
      check("push_restart_count", 32'(pixels_written), 32'd0);
      check("push_restart_done", {31'd0, frame_done}, 32'd0);
      check("push_restart_s_ready", {31'd0, s_ready}, 32'd1);

      // frame_start during PUSH with the sink stalled: pixel dropped
      send_pixel(1'b0, 8'h40, 8'h50, 8'h60);
      @(negedge clk_sys);
      frame_start = 1'b1;
      @(negedge clk_sys);
      frame_start = 1'b0;
      check("drop_count", 32'(pixels_written), 32'd0);
      check("drop_req", {31'd0, vram_req}, 32'd0);
      check("drop_s_ready", {31'd0, s_ready}, 32'd1);
      send_pixel(1'b0, 8'h41, 8'h51, 8'h61);
      push_pixel(model_pixel(1'b0, 8'h41, 8'h51, 8'h61), 0, 1, 1'b0);

      // Randomized frames
      for (int f = 0; f < 8; f++) begin
         fmt = 1'($urandom_range(0, 1));
         fp  = int'($urandom_range(1, 4));
         start_frame(fp, fmt);
         for (int p = 0; p < fp; p++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            send_pixel(fmt, b0, b1, b2);
            push_pixel(model_pixel(fmt, b0, b1, b2), int'($urandom_range(0, 3)),
                       p + 1, (p + 1) == fp);
         end
         last_fp = fp;
      end

      // frame_start with zero pixels in DONE is ignored
      start_frame(0, 1'b1);
      check("zero_fp_busy", {31'd0, busy}, 32'd0);
      check("zero_fp_s_ready", {31'd0, s_ready}, 32'd0);
      check("zero_fp_count", 32'(pixels_written), 32'(last_fp));

      // Asynchronous reset in the middle of a PUSH
      start_frame(1, 1'b0);
      send_pixel(1'b0, 8'hDE, 8'hAD, 8'hBE);
      check("pre_reset_req", {31'd0, vram_req}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_req", {31'd0, vram_req}, 32'd0);
      check("async_pixel", {8'd0, r_vram_out, g_vram_out, b_vram_out}, 32'd0);
      check("async_busy", {31'd0, busy}, 32'd0);
      check("async_count", 32'(pixels_written), 32'd0);
      @(negedge clk_sys);
      reset_n = 1'b1;
      start_frame(0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sys);
         check("post_reset_idle", {31'd0, busy}, 32'd0);
         check("post_reset_s_ready", {31'd0, s_ready}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_vram_writer
